// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: valid/ready front-end, pin driver and clear engine for a 1536x8 single-port SRAM macro.
// Define SRAM_WRVFY_EN to add a read-back verify after every in-range write (VFY state, vfy_err).
module sram_port_ctrl #(
  parameter int WORDS = 1536,
  parameter int AW = 11,
  parameter int DW = 8,
  parameter logic [DW-1:0] INIT_VAL = 8'h00
) (
  input  logic          CK,
  input  logic          RST,
  input  logic          req_vld,
  output logic          req_rdy,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_vld,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  input  logic          init_req,
  output logic          init_busy,
  output logic          CSB,
  output logic          WEB,
  output logic          OEB,
  output logic [AW-1:0] A,
  output logic [DW-1:0] DI,
  input  logic [DW-1:0] DO
`ifdef SRAM_WRVFY_EN
  ,
  output logic          vfy_err
`endif
);
`ifdef SRAM_WRVFY_EN
  typedef enum logic [1:0] {IDLE, INIT, VFY} state_t;
`else
  typedef enum logic [1:0] {IDLE, INIT} state_t;
`endif
  localparam logic [AW-1:0] LAST = AW'(WORDS - 1);
  state_t state;
  logic acc, in_range;
  logic p1_vld, p1_err, p2_vld, p2_err;
`ifdef SRAM_WRVFY_EN
  logic p1_chk, p2_chk;
  logic [DW-1:0] p1_exp, p2_exp;
`endif
  assign req_rdy = (state == IDLE) & ~init_req;
  assign acc = req_vld & req_rdy;
  assign in_range = int'(req_addr) < WORDS;
  always_ff @(posedge CK) begin
    if (RST) begin
      state <= IDLE;
      CSB <= 1'b1;
      WEB <= 1'b1;
      OEB <= 1'b1;
      A <= '0;
      DI <= '0;
      rsp_vld <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      init_busy <= 1'b0;
      p1_vld <= 1'b0;
      p1_err <= 1'b0;
      p2_vld <= 1'b0;
      p2_err <= 1'b0;
`ifdef SRAM_WRVFY_EN
      p1_chk <= 1'b0;
      p2_chk <= 1'b0;
      p1_exp <= '0;
      p2_exp <= '0;
      vfy_err <= 1'b0;
`endif
    end else begin
      OEB <= 1'b0;
      CSB <= 1'b1;
      WEB <= 1'b1;
      // Out-of-range slots travel the pipeline with an error tag instead of touching the macro
      p1_vld <= acc;
      p1_err <= acc & ~in_range;
      p2_vld <= p1_vld;
      p2_err <= p1_err;
      rsp_vld <= p2_vld;
      rsp_err <= p2_err;
      rsp_rdata <= p2_err ? '0 : DO;
`ifdef SRAM_WRVFY_EN
      p1_chk <= 1'b0;
      p2_chk <= p1_chk;
      p2_exp <= p1_exp;
      rsp_err <= p2_err | (p2_chk & (DO != p2_exp));
      if (p2_vld & p2_chk & (DO != p2_exp)) vfy_err <= 1'b1;
`endif
      case (state)
        IDLE: begin
          if (init_req) begin
            state <= INIT;
            CSB <= 1'b0;
            WEB <= 1'b0;
            A <= '0;
            DI <= INIT_VAL;
            init_busy <= 1'b1;
`ifdef SRAM_WRVFY_EN
            vfy_err <= 1'b0;
`endif
          end else if (acc & in_range) begin
            CSB <= 1'b0;
            WEB <= ~req_wr;
            A <= req_addr;
            if (req_wr) DI <= req_wdata;
`ifdef SRAM_WRVFY_EN
            // The write itself yields no response; the follow-up read does
            if (req_wr) begin
              state <= VFY;
              p1_vld <= 1'b0;
            end
`endif
          end
        end
        INIT: begin
          if (A == LAST) begin
            state <= IDLE;
            init_busy <= 1'b0;
          end else begin
            CSB <= 1'b0;
            WEB <= 1'b0;
            A <= A + AW'(1);
          end
        end
`ifdef SRAM_WRVFY_EN
        VFY: begin
          state <= IDLE;
          CSB <= 1'b0;
          p1_vld <= 1'b1;
          p1_chk <= 1'b1;
          p1_exp <= DI;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb_sram_port_ctrl: directed self-checking bench for sram_port_ctrl with a behavioural 1536x8 SRAM model.
module tb_sram_port_ctrl;
`ifdef SRAM_WRVFY_EN
  localparam int WL = 3;
`else
  localparam int WL = 2;
`endif
  logic CK = 1'b0, RST = 1'b1;
  logic req_vld = 1'b0, req_wr = 1'b0, init_req = 1'b0;
  logic [10:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic req_rdy, rsp_vld, rsp_err, init_busy, CSB, WEB, OEB;
  logic [7:0] rsp_rdata, DI, DO;
  logic [10:0] A;
`ifdef SRAM_WRVFY_EN
  logic vfy_err;
`endif
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic stuck = 1'b0;
  logic [7:0] mem [0:2047];
  logic [7:0] do_q = 8'h00;
  typedef struct packed {logic [7:0] d; logic e; int c;} rsp_t;
  rsp_t q[$];

  sram_port_ctrl #(.INIT_VAL(8'hA5)) dut (
    .CK(CK), .RST(RST), .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .init_req(init_req), .init_busy(init_busy), .CSB(CSB), .WEB(WEB),
    .OEB(OEB), .A(A), .DI(DI), .DO(DO)
`ifdef SRAM_WRVFY_EN
    , .vfy_err(vfy_err)
`endif
  );

  always #5 CK = ~CK;
  always @(posedge CK) cyc <= cyc + 1;

  initial for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
  // Macro model: pins sampled on the rising edge, DO follows one edge later; writes read back
  always @(posedge CK) begin
    if (!CSB) begin
      if (!WEB) begin
        mem[A] <= stuck ? 8'h00 : DI;
        do_q <= stuck ? 8'h00 : DI;
      end else do_q <= mem[A];
    end
  end
  assign DO = OEB ? 8'h00 : do_q;

  always @(negedge CK) if (rsp_vld) q.push_back('{d: rsp_rdata, e: rsp_err, c: cyc});

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic idle();
    req_vld = 1'b0;
    req_wr = 1'b0;
  endtask

  task automatic req_one(input logic wr, input logic [10:0] addr, input logic [7:0] data, output int acc);
    req_vld = 1'b1;
    req_wr = wr;
    req_addr = addr;
    req_wdata = data;
    acc = -1;
    for (int i = 0; i < 10 && acc < 0; i++) begin
      #1;
      if (req_rdy) begin
        @(negedge CK);
        acc = cyc;
      end else @(negedge CK);
    end
    n_chk++;
    if (acc < 0) begin n_fail++; $display("FAIL req_accept: addr %h never accepted", addr); end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CK);
    n_chk++; if ({CSB, WEB, OEB} !== 3'b111) begin n_fail++; $display("FAIL reset_pins: got %b want 111", {CSB, WEB, OEB}); end
    n_chk++; if ({A, DI} !== 19'h0) begin n_fail++; $display("FAIL reset_addr_data: got %h/%h want 0/0", A, DI); end
    n_chk++; if ({rsp_vld, rsp_err, init_busy, rsp_rdata} !== 11'h0) begin n_fail++; $display("FAIL reset_rsp: got %b%b%b %h want 0", rsp_vld, rsp_err, init_busy, rsp_rdata); end
    RST = 1'b0;
    @(negedge CK);
    n_chk++; if (OEB !== 1'b0) begin n_fail++; $display("FAIL oeb_release: got %b want 0", OEB); end
    n_chk++; if (req_rdy !== 1'b1) begin n_fail++; $display("FAIL rdy_release: got %b want 1", req_rdy); end
  endtask

  task automatic test_write_read();
    int aw, ar;
    q.delete();
    req_one(1'b1, 11'h123, 8'h5A, aw);
    n_chk++; if ({CSB, WEB, A, DI} !== {2'b00, 11'h123, 8'h5A}) begin n_fail++; $display("FAIL wr_pins: got csb=%b web=%b a=%h di=%h want 0 0 123 5a", CSB, WEB, A, DI); end
    req_one(1'b0, 11'h123, 8'h00, ar);
    idle();
    n_chk++; if ({CSB, WEB, A} !== {2'b01, 11'h123}) begin n_fail++; $display("FAIL rd_pins: got csb=%b web=%b a=%h want 0 1 123", CSB, WEB, A); end
    repeat (5) @(negedge CK);
    n_chk++; if (q.size() != 2) begin n_fail++; $display("FAIL wr_rd_count: got %0d want 2", q.size()); end
    else begin
      n_chk++; if (q[0] !== '{d: 8'h5A, e: 1'b0, c: aw + WL}) begin n_fail++; $display("FAIL wr_rsp: got d=%h e=%b c=%0d want 5a 0 %0d", q[0].d, q[0].e, q[0].c, aw + WL); end
      n_chk++; if (q[1] !== '{d: 8'h5A, e: 1'b0, c: ar + 2}) begin n_fail++; $display("FAIL rd_rsp: got d=%h e=%b c=%0d want 5a 0 %0d", q[1].d, q[1].e, q[1].c, ar + 2); end
    end
  endtask

  task automatic test_back_to_back();
    int acc [8];
    logic [7:0] exp_d [8];
    q.delete();
    for (int i = 0; i < 4; i++) begin
      req_one(1'b1, 11'(i), 8'(8'h10 + i), acc[i]);
      exp_d[i] = 8'(8'h10 + i);
    end
    for (int i = 0; i < 4; i++) begin
      req_one(1'b0, 11'(3 - i), 8'h00, acc[4 + i]);
      exp_d[4 + i] = 8'(8'h13 - i);
    end
    idle();
    repeat (6) @(negedge CK);
    n_chk++; if (q.size() != 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", q.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        n_chk++;
        if (q[i] !== '{d: exp_d[i], e: 1'b0, c: acc[i] + (i < 4 ? WL : 2)}) begin
          n_fail++; $display("FAIL b2b_rsp%0d: got d=%h e=%b c=%0d want %h 0 %0d", i, q[i].d, q[i].e, q[i].c, exp_d[i], acc[i] + (i < 4 ? WL : 2));
        end
      end
`ifndef SRAM_WRVFY_EN
      n_chk++; if (q[7].c - q[0].c != 7) begin n_fail++; $display("FAIL b2b_gapless: got span %0d want 7", q[7].c - q[0].c); end
`endif
    end
  endtask

  task automatic test_out_of_range();
    int a0, a1, a2, d;
    req_one(1'b1, 11'h1FF, 8'h3E, d);
    idle();
    repeat (5) @(negedge CK);
    q.delete();
    req_one(1'b0, 11'h600, 8'h00, a0);
    n_chk++; if (CSB !== 1'b1) begin n_fail++; $display("FAIL oor_rd_csb: got %b want 1", CSB); end
    req_one(1'b1, 11'h7FF, 8'hEE, a1);
    n_chk++; if (CSB !== 1'b1) begin n_fail++; $display("FAIL oor_wr_csb: got %b want 1", CSB); end
    req_one(1'b0, 11'h1FF, 8'h00, a2);
    idle();
    repeat (5) @(negedge CK);
    n_chk++; if (q.size() != 3) begin n_fail++; $display("FAIL oor_count: got %0d want 3", q.size()); end
    else begin
      n_chk++; if (q[0] !== '{d: 8'h00, e: 1'b1, c: a0 + 2}) begin n_fail++; $display("FAIL oor_rd_rsp: got d=%h e=%b c=%0d want 00 1 %0d", q[0].d, q[0].e, q[0].c, a0 + 2); end
      n_chk++; if (q[1] !== '{d: 8'h00, e: 1'b1, c: a1 + 2}) begin n_fail++; $display("FAIL oor_wr_rsp: got d=%h e=%b c=%0d want 00 1 %0d", q[1].d, q[1].e, q[1].c, a1 + 2); end
      n_chk++; if (q[2] !== '{d: 8'h3E, e: 1'b0, c: a2 + 2}) begin n_fail++; $display("FAIL oor_keep: got d=%h e=%b c=%0d want 3e 0 %0d", q[2].d, q[2].e, q[2].c, a2 + 2); end
    end
  endtask

  task automatic test_init();
    int busy, bad, d;
    req_one(1'b1, 11'h5FF, 8'h99, d);
    idle();
    repeat (5) @(negedge CK);
    q.delete();
    init_req = 1'b1;
    req_vld = 1'b1;
    req_wr = 1'b0;
    req_addr = 11'h000;
    #1;
    n_chk++; if (req_rdy !== 1'b0) begin n_fail++; $display("FAIL init_prio_rdy: got %b want 0", req_rdy); end
    @(negedge CK);
    init_req = 1'b0;
    idle();
    n_chk++; if ({init_busy, CSB, WEB, A, DI} !== {3'b100, 11'h000, 8'hA5}) begin n_fail++; $display("FAIL init_start: got busy=%b csb=%b web=%b a=%h di=%h", init_busy, CSB, WEB, A, DI); end
    busy = 0;
    bad = 0;
    for (int i = 0; i < 2000 && init_busy; i++) begin
      if (A !== 11'(busy) || CSB !== 1'b0 || WEB !== 1'b0) bad++;
      if (i == 7) init_req = 1'b1;
      if (i == 8) init_req = 1'b0;
      busy++;
      @(negedge CK);
    end
    n_chk++; if (busy != 1536) begin n_fail++; $display("FAIL init_busy_len: got %0d want 1536", busy); end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL init_walk: got %0d bad cycles want 0", bad); end
    n_chk++; if ({CSB, q.size()} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL init_end: got csb=%b rsps=%0d want 1 0", CSB, q.size()); end
    req_one(1'b0, 11'h000, 8'h00, d);
    req_one(1'b0, 11'h5FF, 8'h00, d);
    idle();
    repeat (5) @(negedge CK);
    n_chk++; if (q.size() != 2) begin n_fail++; $display("FAIL init_rd_count: got %0d want 2", q.size()); end
    else begin
      n_chk++; if ({q[0].d, q[1].d} !== 16'hA5A5) begin n_fail++; $display("FAIL init_rd: got %h %h want a5 a5", q[0].d, q[1].d); end
    end
  endtask

  task automatic test_reset_mid_init();
    int d;
    req_one(1'b1, 11'd50, 8'h11, d);
    req_one(1'b1, 11'd200, 8'h77, d);
    idle();
    repeat (5) @(negedge CK);
    init_req = 1'b1;
    @(negedge CK);
    init_req = 1'b0;
    for (int i = 0; i < 300 && !(init_busy && A == 11'd100); i++) @(negedge CK);
    n_chk++; if (A !== 11'd100) begin n_fail++; $display("FAIL mid_count: got %h want 064", A); end
    RST = 1'b1;
    @(negedge CK);
    n_chk++; if ({CSB, init_busy} !== 2'b10) begin n_fail++; $display("FAIL mid_reset: got csb=%b busy=%b want 1 0", CSB, init_busy); end
    RST = 1'b0;
    @(negedge CK);
    q.delete();
    req_one(1'b0, 11'd50, 8'h00, d);
    req_one(1'b0, 11'd200, 8'h00, d);
    idle();
    repeat (5) @(negedge CK);
    n_chk++; if (q.size() != 2) begin n_fail++; $display("FAIL mid_rd_count: got %0d want 2", q.size()); end
    else begin
      n_chk++; if ({q[0].d, q[1].d} !== 16'hA577) begin n_fail++; $display("FAIL mid_partial: got %h %h want a5 77", q[0].d, q[1].d); end
    end
  endtask

`ifdef SRAM_WRVFY_EN
  task automatic test_verify();
    int a;
    q.delete();
    stuck = 1'b1;
    req_one(1'b1, 11'h020, 8'h3C, a);
    idle();
    repeat (6) @(negedge CK);
    stuck = 1'b0;
    n_chk++; if (q.size() != 1) begin n_fail++; $display("FAIL vfy_count: got %0d want 1", q.size()); end
    else begin
      n_chk++; if (q[0] !== '{d: 8'h00, e: 1'b1, c: a + 3}) begin n_fail++; $display("FAIL vfy_rsp: got d=%h e=%b c=%0d want 00 1 %0d", q[0].d, q[0].e, q[0].c, a + 3); end
    end
    n_chk++; if (vfy_err !== 1'b1) begin n_fail++; $display("FAIL vfy_sticky: got %b want 1", vfy_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_out_of_range();
    test_init();
    test_reset_mid_init();
`ifdef SRAM_WRVFY_EN
    test_verify();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_port_ctrl.md
Name: sram_port_ctrl

Overview:
Synchronous initiator front-end for the single-port 1536x8 SRAM macro. It converts a valid/ready request stream into the macro's CSB/WEB/OEB/A/DI pin protocol and captures DO into an in-order response stream. It also contains a hardware clear engine that fills the array with a constant value. It sits between the digital core's buffer logic and the SRAM hard macro, and it is the only block that drives the macro pins.

Parameters:
WORDS, 1536, number of SRAM words; addresses >= WORDS are out of range
AW, 11, address width
DW, 8, data width
INIT_VAL, 8'h00, value written to every word by the clear engine

Ports:
CK  in  1  clock, rising edge; the same net that clocks the SRAM macro
RST  in  1  reset, synchronous, active-high
req_vld  in  1  request valid
req_rdy  out  1  request ready; combinational = (state==IDLE) & ~init_req
req_wr  in  1  1=write, 0=read
req_addr  in  AW  request address
req_wdata  in  DW  write data
rsp_vld  out  1  response valid, 1-cycle pulse per accepted request
rsp_rdata  out  DW  response data
rsp_err  out  1  response error qualifier
init_req  in  1  start clear engine, pulse
init_busy  out  1  clear engine running
CSB  out  1  to SRAM CSB
WEB  out  1  to SRAM WEB
OEB  out  1  to SRAM OEB
A  out  AW  to SRAM A
DI  out  DW  to SRAM DI
DO  in  DW  from SRAM DO
vfy_err  out  1  sticky write-verify failure; present only with SRAM_WRVFY_EN

Behaviour:
- Clock and reset: one clock, CK. RST is synchronous and active-high. All outputs are registered except req_rdy.
- Reset values: CSB=1, WEB=1, OEB=1, A=0, DI=0, rsp_vld=0, rsp_rdata=0, rsp_err=0, init_busy=0, vfy_err=0, state=IDLE.
- OEB goes to 0 on the first edge after RST deasserts and stays 0.
- States: IDLE, INIT, VFY. VFY exists only with SRAM_WRVFY_EN.
- Pin stage: a request accepted at edge E0 drives pins from E0:
  - in range: CSB=0, WEB=~req_wr, A=req_addr, DI=req_wdata (DI updates on writes only).
  - The macro samples the pins at E1.
- Capture stage: DO is captured at E2. rsp_vld=1 for the cycle following E2.
  - Read latency is 2 cycles.
  - Full throughput: one request per cycle, no bubbles, responses in order.
- Write response: rsp_rdata = captured DO, which is the written data (the macro reads back during a write). rsp_err=0.
- Idle cycles: CSB=1, WEB=1. A and DI hold their last values.
- Out-of-range request (addr >= WORDS): accepted and the pipeline slot is kept, but CSB stays 1. Response follows the same latency with rsp_err=1 and rsp_rdata=0. No aliasing write occurs.
- Clear engine, start:
  - init_req seen in IDLE moves the FSM to INIT at the next edge. init_req has priority over a simultaneous req_vld, which is not accepted.
  - init_req during INIT is ignored.
- Clear engine, run:
  - INIT writes INIT_VAL to addresses 0..WORDS-1, one per cycle (CSB=0, WEB=0).
  - The internal counter does not wrap: after WORDS-1 the FSM returns to IDLE.
  - init_busy is 1 exactly during the WORDS cycles in INIT.
- Clear engine, responses: INIT writes produce no responses. Requests already in the pipeline when INIT starts complete normally.
- Reset mid-operation: the next edge forces the reset values. In-flight responses are dropped and a partial clear stays partial.

Optional Feature:
SRAM_WRVFY_EN
- Defined, pin sequence: each in-range write is followed by one internal read of the same address.
  - State VFY lasts 1 cycle; req_rdy=0 during VFY.
  - The write's response is generated from that read at latency 3.
- Defined, response content: rsp_rdata = readback value. rsp_err = (readback != wdata).
- Defined, sticky flag: vfy_err is set on any mismatch and cleared only by RST or init_req.
- Defined, reads and out-of-range requests are unchanged.
- Undefined: no VFY state and no vfy_err port. Write responses use latency 2 with write-through data.

Test Plan:
1. Reset, then release RST -> during reset CSB=1, WEB=1, OEB=1. One edge after release OEB=0 and req_rdy=1.
2. Write 0x5A to 0x123, then read 0x123 -> pins show A=0x123, WEB=0, DI=0x5A the cycle after accept. Read rsp_vld arrives 2 cycles after its accept with rsp_rdata=0x5A.
3. Back-to-back: write 0x10..0x13 to addresses 0..3, then read addresses 3..0 -> 8 consecutive responses with no gap. Reads return 0x13, 0x12, 0x11, 0x10.
4. Read 0x600 and write 0x7FF, then read 0x1FF -> CSB stays 1 in both out-of-range slots, both responses have rsp_err=1 and rsp_rdata=0. Address 0x1FF keeps its prior value.
5. INIT_VAL=0xA5: assert init_req together with req_vld -> request not accepted. init_busy is high for 1536 cycles while A walks 0x000..0x5FF. Afterwards, reads of 0x000 and 0x5FF return 0xA5.
6. Assert RST at clear count 100 -> CSB=1 after the next edge and init_busy=0. After release, address 50 reads 0xA5 and address 200 reads its pre-clear data. With SRAM_WRVFY_EN, force DO to 0x00 on a 0x3C write -> rsp_err=1 and vfy_err=1.
